// File: rtl/alarm_unit.sv
// alarm_unit: daily hh:mm:00 alarm with stop, snooze, disarm and optional
// auto-silence. Build option: define ALARM_AUTO_SILENCE_EN to end an unattended
// ring after RING_TIMEOUT_S ticks and flag it on 'missed'; otherwise the ring
// persists and 'missed' is constant 0.
module alarm_unit #(
   parameter int SNOOZE_MIN     = 5,
   parameter int MAX_SNOOZE     = 3,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [5:0] cur_sec,
   input  logic [5:0] cur_min,
   input  logic [4:0] cur_hour,
   input  logic       set_en,
   input  logic [4:0] set_hour,
   input  logic [5:0] set_min,
   input  logic       arm,
   input  logic       stop,
   input  logic       snooze,
   output logic       ring,
   output logic [1:0] state,
   output logic [4:0] alarm_hour,
   output logic [5:0] alarm_min,
   output logic       set_err,
   output logic       missed
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RING  = 2'd2;
   localparam logic [1:0] S_SNZ   = 2'd3;

   localparam logic [11:0] SNOOZE_TICKS = 12'(SNOOZE_MIN * 60);
   localparam logic [2:0]  SNOOZE_MAX   = 3'(MAX_SNOOZE);

   // Out-of-range parameters stop elaboration rather than silently truncate.
   if (SNOOZE_MIN < 1 || SNOOZE_MIN > 60 || MAX_SNOOZE < 0 || MAX_SNOOZE > 7 ||
       RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 4095) begin : g_bad_param
      $error("alarm_unit: parameter out of range");
   end

   logic [1:0]  state_q, state_d;
   logic        ring_q, ring_d;
   logic [4:0]  alarm_hour_q, alarm_hour_d;
   logic [5:0]  alarm_min_q, alarm_min_d;
   logic        set_err_q, set_err_d;
   logic [11:0] snooze_left_q, snooze_left_d;
   logic [11:0] ring_cnt_q, ring_cnt_d;
   logic [2:0]  snooze_used_q, snooze_used_d;
   logic        missed_q, missed_d;

   logic        match;
   logic        set_ok;
   logic [11:0] ring_cnt_inc;

   // Match compares against the registered alarm time, so a write in the
   // same cycle only affects later ticks.
   assign match        = tick && (cur_hour == alarm_hour_q) && (cur_min == alarm_min_q) &&
                         (cur_sec == 6'd0);
   assign set_ok       = (set_hour <= 5'd23) && (set_min <= 6'd59);
   assign ring_cnt_inc = (ring_cnt_q == 12'hFFF) ? ring_cnt_q : ring_cnt_q + 12'd1;

   // Next-state: write path, then state transitions in priority order.
   always_comb begin
      state_d       = state_q;
      alarm_hour_d  = alarm_hour_q;
      alarm_min_d   = alarm_min_q;
      set_err_d     = 1'b0;
      snooze_left_d = snooze_left_q;
      ring_cnt_d    = ring_cnt_q;
      snooze_used_d = snooze_used_q;
      missed_d      = missed_q;

      if (set_en) begin
         missed_d = 1'b0;
         if (set_ok) begin
            alarm_hour_d = set_hour;
            alarm_min_d  = set_min;
         end else begin
            set_err_d = 1'b1;
         end
      end

      if (!arm) begin
         state_d       = S_IDLE;
         snooze_used_d = 3'd0;
         missed_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: begin
               if (match) begin
                  state_d       = S_RING;
                  ring_cnt_d    = 12'd0;
                  snooze_used_d = 3'd0;
               end
            end
            S_RING: begin
               if (stop) begin
                  state_d = S_ARMED;
               end else if (snooze && (snooze_used_q < SNOOZE_MAX)) begin
                  state_d       = S_SNZ;
                  snooze_left_d = SNOOZE_TICKS;
                  snooze_used_d = snooze_used_q + 3'd1;
               end else if (tick) begin
                  ring_cnt_d = ring_cnt_inc;
`ifdef ALARM_AUTO_SILENCE_EN
                  if (ring_cnt_inc == 12'(RING_TIMEOUT_S)) begin
                     state_d  = S_ARMED;
                     missed_d = 1'b1;
                  end
`endif
               end
            end
            S_SNZ: begin
               if (stop) begin
                  state_d = S_ARMED;
               end else if (tick) begin
                  if (snooze_left_q == 12'd1) begin
                     state_d    = S_RING;
                     ring_cnt_d = 12'd0;
                  end
                  if (snooze_left_q != 12'd0) snooze_left_d = snooze_left_q - 12'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      ring_d = (state_d == S_RING);
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         ring_q        <= 1'b0;
         alarm_hour_q  <= 5'd0;
         alarm_min_q   <= 6'd0;
         set_err_q     <= 1'b0;
         snooze_left_q <= 12'd0;
         ring_cnt_q    <= 12'd0;
         snooze_used_q <= 3'd0;
         missed_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ring_q        <= ring_d;
         alarm_hour_q  <= alarm_hour_d;
         alarm_min_q   <= alarm_min_d;
         set_err_q     <= set_err_d;
         snooze_left_q <= snooze_left_d;
         ring_cnt_q    <= ring_cnt_d;
         snooze_used_q <= snooze_used_d;
         missed_q      <= missed_d;
      end
   end

   assign ring       = ring_q;
   assign state      = state_q;
   assign alarm_hour = alarm_hour_q;
   assign alarm_min  = alarm_min_q;
   assign set_err    = set_err_q;
`ifdef ALARM_AUTO_SILENCE_EN
   assign missed     = missed_q;
`else
   assign missed     = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: directed vector table, hand-written snooze/stop/reset
// sequences, then random traffic against an elapsed-time reference model.
module tb_alarm_unit;

   localparam int SNOOZE_MIN = 5;
   localparam int MAX_SNOOZE = 3;
   localparam int TIMEOUT    = 60;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic [5:0] cur_sec = '0;
   logic [5:0] cur_min = '0;
   logic [4:0] cur_hour = '0;
   logic       set_en = 1'b0;
   logic [4:0] set_hour = '0;
   logic [5:0] set_min = '0;
   logic       arm = 1'b0;
   logic       stop = 1'b0;
   logic       snooze = 1'b0;
   logic       ring;
   logic [1:0] state;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;
   logic       set_err;
   logic       missed;

   int checks = 0;
   int failures = 0;

   alarm_unit #(.SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE), .RING_TIMEOUT_S(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .tick(tick), .cur_sec(cur_sec), .cur_min(cur_min),
      .cur_hour(cur_hour), .set_en(set_en), .set_hour(set_hour), .set_min(set_min),
      .arm(arm), .stop(stop), .snooze(snooze), .ring(ring), .state(state),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min), .set_err(set_err), .missed(missed)
   );

   always #5 clk = ~clk;

   // Reference model: tracks the mode plus elapsed seconds of ringing/snoozing.
   int m_st, m_ah, m_am, m_err, m_missed, m_used, m_ring_s, m_snz_s;

   task automatic model_reset();
      m_st = 0; m_ah = 0; m_am = 0; m_err = 0; m_missed = 0;
      m_used = 0; m_ring_s = 0; m_snz_s = 0;
   endtask

   task automatic model_step();
      bit hit;
      hit = tick && (int'(cur_hour) == m_ah) && (int'(cur_min) == m_am) && (cur_sec == 0);
      m_err = 0;
      if (set_en) begin
         m_missed = 0;
         if (set_hour <= 23 && set_min <= 59) begin
            m_ah = int'(set_hour);
            m_am = int'(set_min);
         end else m_err = 1;
      end
      if (!arm) begin
         m_st = 0; m_used = 0; m_missed = 0;
      end else if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
         if (hit) begin m_st = 2; m_ring_s = 0; m_used = 0; end
      end else if (m_st == 2) begin
         if (stop) m_st = 1;
         else if (snooze && m_used < MAX_SNOOZE) begin m_st = 3; m_snz_s = 0; m_used++; end
         else if (tick) begin
            if (m_ring_s < 4095) m_ring_s++;
`ifdef ALARM_AUTO_SILENCE_EN
            if (m_ring_s == TIMEOUT) begin m_st = 1; m_missed = 1; end
`endif
         end
      end else begin
         if (stop) m_st = 1;
         else if (tick) begin
            m_snz_s++;
            if (m_snz_s == SNOOZE_MIN * 60) begin m_st = 2; m_ring_s = 0; end
         end
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock: model consumes the current inputs, outputs sampled 1ns after the edge.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulses_off();
      set_en = 0; stop = 0; snooze = 0; tick = 0;
   endtask

   task automatic tick_n(input int n, input int h, input int m, input int s);
      for (int i = 0; i < n; i++) begin
         tick = 1; cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
         step();
         tick = 0;
      end
   endtask

   typedef struct {
      bit set_en; int sh; int sm; bit arm; bit stop; bit snz; bit tick;
      int h; int m; int s;
      int e_st; int e_ring; int e_err; int e_ah; int e_am;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1, 7, 30, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 7, 30};
      tbl[1] = '{1, 24, 10, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 7, 30};
      tbl[2] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0,    1, 0, 0, 7, 30};
      tbl[3] = '{0, 0, 0, 1, 0, 0, 1, 7, 29, 59,  1, 0, 0, 7, 30};
      tbl[4] = '{0, 0, 0, 1, 0, 0, 1, 7, 30, 0,   2, 1, 0, 7, 30};
      tbl[5] = '{0, 0, 0, 1, 0, 0, 0, 7, 30, 1,   2, 1, 0, 7, 30};
      tbl[6] = '{0, 0, 0, 1, 0, 1, 0, 7, 30, 1,   3, 0, 0, 7, 30};

      // Reset state, sampled while reset is held.
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_ring", ring, 0);
      chk("rst_err", set_err, 0);
      chk("rst_missed", missed, 0);
      chk("rst_alarm", {alarm_hour, alarm_min}, 0);
      reset = 1;

      // Table: program, reject, arm, match, snooze.
      foreach (tbl[i]) begin
         set_en = tbl[i].set_en; set_hour = 5'(tbl[i].sh); set_min = 6'(tbl[i].sm);
         arm = tbl[i].arm; stop = tbl[i].stop; snooze = tbl[i].snz; tick = tbl[i].tick;
         cur_hour = 5'(tbl[i].h); cur_min = 6'(tbl[i].m); cur_sec = 6'(tbl[i].s);
         step();
         pulses_off();
         chk($sformatf("vec%0d_state", i), state, tbl[i].e_st);
         chk($sformatf("vec%0d_ring", i), ring, tbl[i].e_ring);
         chk($sformatf("vec%0d_err", i), set_err, tbl[i].e_err);
         chk($sformatf("vec%0d_ahour", i), alarm_hour, tbl[i].e_ah);
         chk($sformatf("vec%0d_amin", i), alarm_min, tbl[i].e_am);
      end

      // Snooze lasts exactly 300 ticks.
      tick_n(299, 7, 30, 1);
      chk("snz299_state", state, 3);
      chk("snz299_ring", ring, 0);
      tick_n(1, 7, 30, 1);
      chk("snz300_ring", ring, 1);
      chk("snz300_state", state, 2);

      // Second and third snooze honoured, fourth ignored.
      for (int k = 2; k <= 3; k++) begin
         snooze = 1; step(); pulses_off();
         chk($sformatf("snz%0d_state", k), state, 3);
         tick_n(300, 7, 30, 1);
         chk($sformatf("snz%0d_rering", k), ring, 1);
      end
      snooze = 1; step(); pulses_off();
      chk("snz4_ring", ring, 1);
      chk("snz4_state", state, 2);

      // stop + snooze + tick together: stop wins.
      stop = 1; snooze = 1; tick = 1; cur_sec = 6'd5;
      step(); pulses_off();
      chk("combo_state", state, 1);
      chk("combo_ring", ring, 0);

      // Disarm during snooze.
      tick_n(1, 7, 30, 0);
      chk("rering_state", state, 2);
      snooze = 1; step(); pulses_off();
      chk("snz_again_state", state, 3);
      arm = 0; step();
      chk("disarm_state", state, 0);
      chk("disarm_ring", ring, 0);

      // Long unattended ring.
      arm = 1; step();
      chk("rearm_state", state, 1);
      tick_n(1, 7, 30, 0);
      chk("long_start_ring", ring, 1);
`ifdef ALARM_AUTO_SILENCE_EN
      tick_n(59, 7, 30, 1);
      chk("to59_state", state, 2);
      tick_n(1, 7, 30, 1);
      chk("to60_state", state, 1);
      chk("to60_ring", ring, 0);
      chk("to60_missed", missed, 1);
      set_en = 1; set_hour = 5'd6; set_min = 6'd0; step(); pulses_off();
      chk("set_clears_missed", missed, 0);
      chk("set_new_hour", alarm_hour, 6);
`else
      tick_n(200, 7, 30, 1);
      chk("ring200_ring", ring, 1);
      chk("ring200_state", state, 2);
      chk("ring200_missed", missed, 0);
`endif

      // Asynchronous reset mid-ring.
      stop = 1; step(); pulses_off();
      set_en = 1; set_hour = 5'd8; set_min = 6'd15; step(); pulses_off();
      tick_n(1, 8, 15, 0);
      chk("pre_rst_ring", ring, 1);
      #2 reset = 0;
      #1;
      chk("async_rst_ring", ring, 0);
      chk("async_rst_state", state, 0);
      chk("async_rst_alarm", {alarm_hour, alarm_min}, 0);
      @(posedge clk);
      #1 reset = 1;
      model_reset();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         arm    = ($urandom_range(0, 99) < 97);
         stop   = ($urandom_range(0, 99) < 3);
         snooze = ($urandom_range(0, 99) < 4);
         tick   = ($urandom_range(0, 1) == 1);
         set_en = ($urandom_range(0, 99) < 3);
         set_hour = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 1));
         set_min  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 1));
         cur_hour = 5'($urandom_range(0, 1));
         cur_min  = 6'($urandom_range(0, 1));
         cur_sec  = 6'($urandom_range(0, 1));
         step();
         checks++;
         if (state != 2'(m_st) || ring != (m_st == 2) || set_err != 1'(m_err) ||
             missed != 1'(m_missed) || alarm_hour != 5'(m_ah) || alarm_min != 6'(m_am)) begin
            failures++;
            $display("FAIL rand_c%0d: got st=%0d ring=%0d err=%0d missed=%0d alarm=%0d:%0d expected st=%0d ring=%0d err=%0d missed=%0d alarm=%0d:%0d",
                     c, state, ring, set_err, missed, alarm_hour, alarm_min,
                     m_st, (m_st == 2), m_err, m_missed, m_ah, m_am);
         end
      end
      pulses_off();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Daily alarm stage downstream of the time-of-day counters. It watches the running hours, minutes and seconds together with the one-second tick that advances them. At a programmed hh:mm:00 it raises a ring output, and it manages stop, snooze, disarm and optional auto-silence. It sits between the time counters and the buzzer/LED driver.

## Interface
- SNOOZE_MIN, default 5: snooze length in minutes; legal range 1..60.
- MAX_SNOOZE, default 3: snoozes allowed per alarm event; legal range 0..7.
- RING_TIMEOUT_S, default 60: auto-silence length in ticks; legal range 1..4095.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle strobe, once per second; same strobe that advances the time counters.
- cur_sec  in  6  current seconds, 0..59.
- cur_min  in  6  current minutes, 0..59.
- cur_hour  in  5  current hours, 0..23.
- set_en  in  1  one-cycle write of alarm time.
- set_hour  in  5  alarm hour to write.
- set_min  in  6  alarm minute to write.
- arm  in  1  level; 1 = alarm enabled, 0 = disarm.
- stop  in  1  one-cycle request: silence and re-arm for the next day.
- snooze  in  1  one-cycle request: silence for SNOOZE_MIN minutes.
- ring  out  1  alarm sounding.
- state  out  2  0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE.
- alarm_hour  out  5  stored alarm hour.
- alarm_min  out  6  stored alarm minute.
- set_err  out  1  one-cycle pulse: rejected write.
- missed  out  1  sticky: alarm auto-silenced without stop or snooze.

## Operation
- Reset values:
  - state = IDLE, ring = 0, set_err = 0, missed = 0.
  - alarm_hour = 0, alarm_min = 0.
  - Internal counters cleared: snooze_left, ring_cnt, snooze_used.
- Write path, accepted in any state:
  - set_en with set_hour ≤ 23 and set_min ≤ 59 updates the alarm registers. State is unchanged.
  - Any other set_en leaves the registers unchanged and pulses set_err for one cycle.
- Match condition: tick=1 and cur_hour==alarm_hour and cur_min==alarm_min and cur_sec==0. Inputs are sampled in the tick cycle.
- State transitions, priority highest first:
  - arm=0, any state → IDLE; clears snooze_used.
  - IDLE with arm=1 → ARMED.
  - ARMED with match → RINGING; ring_cnt=0, snooze_used=0.
  - RINGING with stop → ARMED.
  - RINGING with snooze and snooze_used < MAX_SNOOZE → SNOOZE; snooze_left = SNOOZE_MIN*60; snooze_used+1.
  - RINGING with snooze and snooze_used == MAX_SNOOZE: snooze ignored; state stays RINGING.
  - RINGING with tick: ring_cnt+1. Timeout behaviour is under Configuration.
  - SNOOZE with stop → ARMED.
  - SNOOZE with tick: snooze_left−1. A tick arriving with snooze_left==1 → RINGING, ring_cnt=0.
- stop, snooze and tick in the same cycle: stop/snooze win; the tick is not counted.
- Match while in RINGING or SNOOZE is ignored; no restart.
- missed:
  - Set on auto-silence.
  - Cleared by set_en (accepted or rejected) or by arm=0.
- Widths:
  - snooze_left and ring_cnt: 12 bits, no wrap; they stop at their terminal value.
  - snooze_used: 3 bits.

## Timing
- All outputs registered.
- ring rises on the first clk edge after the matching tick cycle, i.e. latency 1 cycle, and falls on the edge that leaves RINGING.
- stop/snooze take effect on the next edge: ring=0 one cycle after the request.
- alarm_hour/alarm_min update the cycle after set_en. A match in that same set_en cycle uses the old values.
- Reset asserted mid-ring clears ring immediately (asynchronous). After release, the block waits one edge in IDLE before arm is honoured.

## Configuration
- ALARM_AUTO_SILENCE_EN defined: RINGING with a tick that makes ring_cnt == RING_TIMEOUT_S → ARMED, ring=0, missed=1.
- ALARM_AUTO_SILENCE_EN undefined:
  - RINGING persists until stop, snooze or disarm.
  - ring_cnt saturates at 4095.
  - missed is tied to 0.

## Test plan
- Defaults; set 07:30, arm=1; drive 07:29:59 tick, then 07:30:00 tick → ring=1 one cycle after the 07:30:00 tick, state=2.
- Ringing; snooze pulse → ring=0, state=3. After exactly 300 ticks ring=1 again. Four snooze attempts → only 3 honoured; the 4th leaves ring=1.
- set_en with set_hour=24, set_min=10 → set_err one-cycle pulse; alarm_hour/alarm_min unchanged.
- With ALARM_AUTO_SILENCE_EN: ring for 60 ticks → state=1, ring=0, missed=1. Next set_en clears missed. Without the macro, ring is still 1 after 200 ticks.
- Ringing with stop, snooze and tick asserted in the same cycle → state=1, ring=0. arm=0 during SNOOZE → state=0.
- reset low mid-ring → ring=0, state=0, alarm_hour=0 and alarm_min=0 before the next clk edge.
